// File: rtl/float_addsub_pipeline_if.sv
// Request/response bundle for the float add/sub pipeline: operands and tag in,
// result, tag and flags out.
interface float_addsub_pipeline_if #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int TAG_WIDTH  = 4
);
    localparam int W = 1 + EXP_WIDTH + MANT_WIDTH;

    logic                 req;
    logic                 sub;
    logic [TAG_WIDTH-1:0] tag_in;
    logic [W-1:0]         a;
    logic [W-1:0]         b;
    logic                 ack;
    logic [W-1:0]         out;
    logic [TAG_WIDTH-1:0] tag_out;
    logic                 ovf;
    logic                 unf;

    modport master (
        output req, sub, tag_in, a, b,
        input  ack, out, tag_out, ovf, unf
    );

    modport slave (
        input  req, sub, tag_in, a, b,
        output ack, out, tag_out, ovf, unf
    );
endinterface

// File: rtl/float_addsub_pipeline.sv
// Four-stage pipelined float adder/subtractor: unpack/compare, align/add,
// normalise, pack. Truncating rounding, denormals flushed, one request per cycle.
module float_addsub_pipeline #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    float_addsub_pipeline_if.slave  bus
);
    localparam int W    = 1 + EXP_WIDTH + MANT_WIDTH;
    localparam int SIGW = MANT_WIDTH + 1;  // significand with hidden bit
    localparam int MX   = SIGW + 3;        // plus three guard bits
    localparam int SW   = MX + 1;          // plus carry
    localparam int LZW  = $clog2(MX + 1);
    localparam int EI   = EXP_WIDTH + LZW + 2;

    localparam logic signed [EI-1:0] EXP_MAX  = EI'((1 << EXP_WIDTH) - 1);
    localparam logic signed [EI-1:0] EXP_ZERO = '0;

    // ---------------- stage 1: unpack / compare ----------------
    logic [EXP_WIDTH-1:0] w_exp_a, w_exp_b;
    logic [SIGW-1:0]      w_sig_a, w_sig_b;
    logic                 w_sign_a, w_sign_b_eff, w_swap;

    assign w_exp_a      = bus.a[W-2 -: EXP_WIDTH];
    assign w_exp_b      = bus.b[W-2 -: EXP_WIDTH];
    assign w_sig_a      = (w_exp_a == '0) ? '0 : {1'b1, bus.a[MANT_WIDTH-1:0]};
    assign w_sig_b      = (w_exp_b == '0) ? '0 : {1'b1, bus.b[MANT_WIDTH-1:0]};
    assign w_sign_a     = bus.a[W-1];
    assign w_sign_b_eff = bus.b[W-1] ^ bus.sub;
    // Zeroed significands make flushed operands compare as the smallest magnitude.
    assign w_swap       = {w_exp_b, w_sig_b} > {w_exp_a, w_sig_a};

    logic                 r_s1_valid;
    logic [TAG_WIDTH-1:0] r_s1_tag;
    logic                 r_s1_sign_x, r_s1_eff_sub;
    logic [EXP_WIDTH-1:0] r_s1_exp_x, r_s1_diff;
    logic [SIGW-1:0]      r_s1_sig_x, r_s1_sig_y;

    // ---------------- stage 2: align / add ----------------
    logic [MX-1:0] w_x_ext, w_y_ext, w_y_shift;
    logic [SW-1:0] w_sum;

    assign w_x_ext   = {r_s1_sig_x, 3'b000};
    assign w_y_ext   = {r_s1_sig_y, 3'b000};
    assign w_y_shift = (int'(r_s1_diff) >= MX) ? '0 : (w_y_ext >> r_s1_diff);
    assign w_sum     = r_s1_eff_sub ? ({1'b0, w_x_ext} - {1'b0, w_y_shift})
                                    : ({1'b0, w_x_ext} + {1'b0, w_y_shift});

    logic                 r_s2_valid;
    logic [TAG_WIDTH-1:0] r_s2_tag;
    logic                 r_s2_sign;
    logic [EXP_WIDTH-1:0] r_s2_exp;
    logic [SW-1:0]        r_s2_sum;

    // ---------------- stage 3: normalise ----------------
    logic [LZW-1:0]       w_lz;
    logic                 w_carry;
    logic [MX-1:0]        w_norm;
    logic signed [EI-1:0] w_exp_n;
    logic                 w_unused;

    // NOTE: every always_comb output gets a default before the loop/branches so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_lz = LZW'(MX);
        for (int i = 0; i < MX; i++) begin
            if (r_s2_sum[i]) w_lz = LZW'(MX - 1 - i);
        end
    end

    assign w_carry  = r_s2_sum[SW-1];
    assign w_norm   = w_carry ? r_s2_sum[SW-1:1] : (r_s2_sum[MX-1:0] << w_lz);
    assign w_exp_n  = w_carry ? (EI'(r_s2_exp) + EI'(1)) : (EI'(r_s2_exp) - EI'(w_lz));
    assign w_unused = ^{w_norm[MX-1], w_norm[2:0]};

    logic                   r_s3_valid;
    logic [TAG_WIDTH-1:0]   r_s3_tag;
    logic                   r_s3_sign, r_s3_zero;
    logic signed [EI-1:0]   r_s3_exp;
    logic [MANT_WIDTH-1:0]  r_s3_man;

    // ---------------- stage 4: pack ----------------
    logic [W-1:0] w_pack_out;
    logic         w_pack_ovf, w_pack_unf;

    always_comb begin
        w_pack_out = '0;
        w_pack_ovf = 1'b0;
        w_pack_unf = 1'b0;
        if (!r_s3_zero) begin
            if (r_s3_exp >= EXP_MAX) begin
                w_pack_out = {r_s3_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
                w_pack_ovf = 1'b1;
            end else if (r_s3_exp <= EXP_ZERO) begin
                w_pack_unf = 1'b1;
            end else begin
                w_pack_out = {r_s3_sign, r_s3_exp[EXP_WIDTH-1:0], r_s3_man};
            end
        end
    end

    logic                 r_ack, r_ovf, r_unf;
    logic [W-1:0]         r_out;
    logic [TAG_WIDTH-1:0] r_tag_out;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_ack      <= 1'b0;
            r_out      <= '0;
            r_tag_out  <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_s1_valid <= bus.req;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
            r_ack      <= r_s3_valid;
            if (r_s3_valid) begin
                r_out     <= w_pack_out;
                r_tag_out <= r_s3_tag;
                r_ovf     <= w_pack_ovf;
                r_unf     <= w_pack_unf;
            end
        end
    end

    // NOTE: stage payload registers are deliberately not reset; the valid bits
    // gate everything visible, so resetting the wide datapath buys nothing.
    always_ff @(posedge clk) begin
        r_s1_tag     <= bus.tag_in;
        r_s1_sign_x  <= w_swap ? w_sign_b_eff : w_sign_a;
        r_s1_eff_sub <= w_sign_a ^ w_sign_b_eff;
        r_s1_exp_x   <= w_swap ? w_exp_b : w_exp_a;
        r_s1_diff    <= w_swap ? (w_exp_b - w_exp_a) : (w_exp_a - w_exp_b);
        r_s1_sig_x   <= w_swap ? w_sig_b : w_sig_a;
        r_s1_sig_y   <= w_swap ? w_sig_a : w_sig_b;

        r_s2_tag     <= r_s1_tag;
        r_s2_sign    <= r_s1_sign_x;
        r_s2_exp     <= r_s1_exp_x;
        r_s2_sum     <= w_sum;

        r_s3_tag     <= r_s2_tag;
        r_s3_sign    <= r_s2_sign;
        r_s3_zero    <= (r_s2_sum == '0);
        r_s3_exp     <= w_exp_n;
        r_s3_man     <= w_norm[MX-2:3];
    end

    assign bus.ack     = r_ack;
    assign bus.out     = r_out;
    assign bus.tag_out = r_tag_out;
    assign bus.ovf     = r_ovf;
    assign bus.unf     = r_unf;
endmodule

// File: doc/float_addsub_pipeline.md
# float_addsub_pipeline

Fully pipelined, parametrised floating-point adder/subtractor for the float datapath. It is the successor to the single-request float adder and adds four things: configurable exponent and mantissa widths, a per-request add/subtract mode, a passthrough tag, and overflow/underflow flags. It accepts a new request every cycle with fixed 4-cycle latency, so shader ALU lanes can stream operands without waiting for each ack.

## Interface
- EXP_WIDTH, 8, exponent field width (bias 2^(EXP_WIDTH-1)-1)
- MANT_WIDTH, 23, stored mantissa width (implicit leading 1)
- TAG_WIDTH, 4, width of opaque request tag
- (W = 1 + EXP_WIDTH + MANT_WIDTH; packing is sign, exponent, mantissa, MSB to LSB)

- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low
- req  input  1  request valid; operands sampled on the rising edge while high
- sub  input  1  0: a+b, 1: a-b
- tag_in  input  TAG_WIDTH  returned unchanged with result
- a  input  W  operand A
- b  input  W  operand B
- ack  output  1  result valid; one cycle per accepted request
- out  output  W  result
- tag_out  output  TAG_WIDTH  tag of the request being acked
- ovf  output  1  result overflowed (valid with ack)
- unf  output  1  nonzero result flushed to zero (valid with ack)

## Operation
- Stage 1 (unpack/compare):
  - An exponent field of 0 means zero; the mantissa is ignored (denormals flush to zero).
  - Effective sign of B is sign(b) XOR sub.
  - Swap so that |X| >= |Y|, comparing {exp, mant}.
  - Register diff = expX - expY and eff_sub = signX XOR effsignY.
- Stage 2 (align/add):
  - Mantissas extended to 1+MANT_WIDTH bits (hidden 1) plus 3 low guard bits.
  - Y is right-shifted by diff; a shift >= MANT_WIDTH+4 gives 0.
  - Sum or difference is computed with 1 carry bit.
- Stage 3 (normalise):
  - On carry-out, shift right 1 and increment the exponent.
  - Otherwise, a leading-zero count drives a left shift; the exponent is decremented by that count.
- Stage 4 (pack):
  - Rounding is truncation (round toward zero); guard bits are discarded.
  - A zero magnitude result gives +0 (all bits 0). This includes exact cancellation and both inputs zero.
  - Exponent >= 2^EXP_WIDTH-1 gives out = {signX, all-ones exp, 0 mant} and ovf=1.
  - Exponent <= 0 with a nonzero magnitude gives out = +0 and unf=1.
  - Result sign is signX, the sign of the larger-magnitude operand.
- Inputs with an all-ones exponent (Inf/NaN) are unsupported. The result value is don't-care, but ack and tag timing are unaffected.
- Each stage carries a valid bit and tag alongside its data. There is no backpressure; a pipeline bubble is simply a stage whose valid bit is 0.

## Timing
- Reset (rst low, asynchronous): all stage valid bits, ack, out, tag_out, ovf and unf go to 0 immediately. In-flight requests are discarded and never acked.
- Release of rst is synchronous to clk; the first request is accepted on the first rising edge with rst high.
- Latency: req sampled high at edge k gives ack=1 after edge k+3, with out, tag_out, ovf and unf valid in that same cycle.
- Throughput: 1 request per cycle. N consecutive req cycles give N consecutive ack cycles in issue order.
- ack is high exactly one cycle per request; idle cycles propagate as ack=0.
- out, tag_out, ovf and unf hold the last completed result while ack=0. They update only on edges where stage 4 is valid.
- Inputs a, b, sub and tag_in are don't-care when req=0.

## Test plan
- Reset, then 1.0+1.0 (0x3F800000, 0x3F800000) at edge k -> ack only after edge k+3, out=0x40000000. Afterwards ack=0 and out holds.
- Back-to-back, edges k..k+3:
  - 2.0+3.0 (tag 0) -> 0x40A00000
  - 2000+300 (tag 1) -> 2300.0
  - -5.1+-3.2 (tag 2) -> -8.3 within 1 ulp
  - 1.25+-1.5 (tag 3) -> 0xBE800000 (-0.25)
  - Required response: ack high on edges k+3..k+6, tags 0,1,2,3 in order.
- sub=1:
  - 5.0-3.0 -> 0x40000000
  - 1.5-1.5 -> 0x00000000, ovf=0, unf=0
  - -1.25-(-1.5) -> 0x3E800000
- Alignment and truncation:
  - 1.0 + 2^-30 -> 0x3F800000 exactly
  - 0x3F800001 + 0x33800000 (2^-24) -> 0x3F800001
- Flags:
  - 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000 with ovf=1
  - 0x00800000-0x00800001 -> 0x00000000 with unf=1
- Reset mid-operation: issue 3 requests, pulse rst low after edge k+1 -> ack, out and tag_out go 0 asynchronously, and no ack follows. A new request after release completes normally in 4 cycles.
